// File: rtl/rs_encoder_gf32_if.sv
// Streaming valid/ready bundle for the GF(2^5) RS encoder: message symbols in, codeword symbols out.
// The encoder takes the slave view; the producer/consumer side takes the master view.
interface rs_encoder_gf32_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       out_sop;
  logic       out_eop;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop
  );
endinterface

// File: rtl/rs_encoder_gf32.sv
// Systematic RS(N,K) encoder over GF(2^5), p(x)=x^5+x^2+1, 4 parity symbols, one symbol per clock.
// Optional RSENC_ERR_INJECT_EN adds inj_pos/inj_mask ports that corrupt one emitted symbol per codeword.
module rs_encoder_gf32 #(
  parameter int K = 27
) (
  input  logic                clock,
  input  logic                reset_n,
`ifdef RSENC_ERR_INJECT_EN
  input  logic [4:0]          inj_pos,
  input  logic [4:0]          inj_mask,
`endif
  rs_encoder_gf32_if.slave    bus
);

  localparam int         N        = K + 4;
  localparam logic [4:0] LAST_MSG = 5'(K - 1);
  localparam logic [4:0] LAST_SYM = 5'(N - 1);
  // g(x) low-order coefficients g0..g3; g4 = 1 is implicit
  localparam logic [4:0] GEN [4] = '{5'd17, 5'd9, 5'd6, 5'd30};

  typedef enum logic {DATA, PARITY} state_t;

  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] acc;
    logic [4:0] aa;
    acc = 5'd0;
    aa  = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[3:0], 1'b0} ^ (aa[4] ? 5'h05 : 5'h00);
    end
    return acc;
  endfunction

  state_t     state_reg;
  logic [4:0] cnt_reg;
  logic [4:0] par_reg [4];
  logic [4:0] par_next [4];
  logic       out_valid_reg;
  logic [4:0] out_data_reg;
  logic       out_sop_reg;
  logic       out_eop_reg;

  logic       adv;
  logic       in_fire;
  logic [4:0] fb;
  logic [4:0] corrupt;

  assign adv     = !out_valid_reg || bus.out_ready;
  // reset_n gates in_ready so nothing is accepted while the encoder is held in reset
  assign bus.in_ready = reset_n && (state_reg == DATA) && adv;
  assign in_fire = bus.in_valid && bus.in_ready;
  assign fb      = bus.in_data ^ par_reg[3];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_par
      if (gi == 0) begin : g_low
        assign par_next[gi] = gf_mul(fb, GEN[gi]);
      end else begin : g_high
        assign par_next[gi] = par_reg[gi-1] ^ gf_mul(fb, GEN[gi]);
      end
    end
  endgenerate

`ifdef RSENC_ERR_INJECT_EN
  logic [4:0] inj_pos_reg;
  logic [4:0] inj_mask_reg;
  logic [4:0] pos_cur;
  logic [4:0] mask_cur;
  // index 0 uses the live ports; the rest of the codeword uses the values captured with it
  assign pos_cur  = (cnt_reg == 5'd0) ? inj_pos  : inj_pos_reg;
  assign mask_cur = (cnt_reg == 5'd0) ? inj_mask : inj_mask_reg;
  assign corrupt  = (cnt_reg == pos_cur) ? mask_cur : 5'd0;
`else
  assign corrupt  = 5'd0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= DATA;
      cnt_reg       <= 5'd0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 5'd0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      for (int i = 0; i < 4; i++) par_reg[i] <= 5'd0;
`ifdef RSENC_ERR_INJECT_EN
      inj_pos_reg   <= 5'd0;
      inj_mask_reg  <= 5'd0;
`endif
    end else begin
      case (state_reg)
        DATA: begin
          if (in_fire) begin
            out_data_reg  <= bus.in_data ^ corrupt;
            out_valid_reg <= 1'b1;
            out_sop_reg   <= (cnt_reg == 5'd0);
            out_eop_reg   <= 1'b0;
            par_reg       <= par_next;
            cnt_reg       <= cnt_reg + 5'd1;
            if (cnt_reg == LAST_MSG) state_reg <= PARITY;
`ifdef RSENC_ERR_INJECT_EN
            if (cnt_reg == 5'd0) begin
              inj_pos_reg  <= inj_pos;
              inj_mask_reg <= inj_mask;
            end
`endif
          end else if (adv) begin
            out_valid_reg <= 1'b0;
          end
        end
        PARITY: begin
          if (adv) begin
            out_data_reg  <= par_reg[3] ^ corrupt;
            out_valid_reg <= 1'b1;
            out_sop_reg   <= 1'b0;
            out_eop_reg   <= (cnt_reg == LAST_SYM);
            par_reg[3]    <= par_reg[2];
            par_reg[2]    <= par_reg[1];
            par_reg[1]    <= par_reg[0];
            par_reg[0]    <= 5'd0;
            if (cnt_reg == LAST_SYM) begin
              cnt_reg   <= 5'd0;
              state_reg <= DATA;
            end else begin
              cnt_reg   <= cnt_reg + 5'd1;
            end
          end
        end
        default: state_reg <= DATA;
      endcase
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sop   = out_sop_reg;
  assign bus.out_eop   = out_eop_reg;

endmodule

// File: tb/tb_rs_encoder_gf32.sv
// Directed bench for rs_encoder_gf32 (K=27): hand-derived parity vectors, stalls/gaps,
// syndrome check on random messages, mid-parity reset and (if enabled) error injection.
module tb_rs_encoder_gf32;

  localparam int K = 27;
  localparam int N = K + 4;
  localparam int MAX_CYC = 2000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  rs_encoder_gf32_if bus();

`ifdef RSENC_ERR_INJECT_EN
  logic [4:0] inj_pos = 5'd0;
  logic [4:0] inj_mask = 5'd0;
`endif

  rs_encoder_gf32 #(.K(K)) dut (
    .clock   (clock),
    .reset_n (reset_n),
`ifdef RSENC_ERR_INJECT_EN
    .inj_pos (inj_pos),
    .inj_mask(inj_mask),
`endif
    .bus     (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [4:0] msg      [K];
  logic [4:0] got_data [N];
  logic [N-1:0] got_sop;
  logic [N-1:0] got_eop;
  int         got_cnt;
  int         cyc;
  int         rdy_cycles;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] r = 5'd0;
    for (int i = 4; i >= 0; i--) begin
      r = {r[3:0], 1'b0} ^ (r[4] ? 5'h05 : 5'h00);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  task automatic set_msg(input int ia, input logic [4:0] va, input int ib, input logic [4:0] vb);
    for (int i = 0; i < K; i++) msg[i] = 5'd0;
    if (ia >= 0) msg[ia] = va;
    if (ib >= 0) msg[ib] = vb;
  endtask

  // Feeds msg, collects up to 'stop_at' output symbols, with random stalls/gaps in percent.
  task automatic run_cw(input int stall_pct, input int gap_pct, input int stop_at);
    int  sent = 0;
    logic acc = 1'b0;
    got_cnt = 0; cyc = 0; rdy_cycles = 0; got_sop = '0; got_eop = '0;
    while (got_cnt < stop_at && cyc < MAX_CYC) begin
      @(negedge clock);
      if (acc) bus.in_valid = 1'b0;
      if (!bus.in_valid && sent < K && $urandom_range(99) >= gap_pct) begin
        bus.in_valid = 1'b1;
        bus.in_data  = msg[sent];
      end
      bus.out_ready = ($urandom_range(99) >= stall_pct);
      #1;
      if (bus.in_ready) rdy_cycles++;
      acc = bus.in_valid && bus.in_ready;
      if (acc) sent++;
      if (bus.out_valid && bus.out_ready) begin
        got_data[got_cnt] = bus.out_data;
        got_sop[got_cnt]  = bus.out_sop;
        got_eop[got_cnt]  = bus.out_eop;
        got_cnt++;
      end
      cyc++;
    end
    if (got_cnt < stop_at) check_eq("timeout", got_cnt, stop_at);
    @(negedge clock);
    if (acc) bus.in_valid = 1'b0;
  endtask

  task automatic check_cw(input string tag, input logic [19:0] par);
    for (int i = 0; i < K; i++)
      check_eq($sformatf("%s d%0d", tag, i), got_data[i], msg[i]);
    for (int j = 0; j < 4; j++)
      check_eq($sformatf("%s p%0d", tag, K + j), got_data[K+j], par[19-5*j -: 5]);
    check_eq({tag, " sop"}, got_sop, 1);
    check_eq({tag, " eop"}, got_eop, 32'(1) << (N - 1));
    $display("[TB] codeword %s: %0d cycles", tag, cyc);
  endtask

  task automatic check_synd(input string tag);
    logic [4:0] s;
    logic [4:0] root;
    root = 5'd1;
    for (int j = 1; j <= 4; j++) begin
      root = gf_mul(root, 5'd2);
      s = 5'd0;
      for (int i = 0; i < N; i++) s = gf_mul(s, root) ^ got_data[i];
      check_eq($sformatf("%s S%0d", tag, j), s, 0);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 5'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check_eq("rst out_valid", bus.out_valid, 0);
    check_eq("rst out_data", bus.out_data, 0);
    check_eq("rst sop_eop", {bus.out_sop, bus.out_eop}, 0);
    check_eq("rst in_ready", bus.in_ready, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_eq("post-rst in_ready", bus.in_ready, 1);

    set_msg(-1, 5'd0, -1, 5'd0);
    run_cw(0, 0, N);
    check_cw("zero", 20'd0);
    check_eq("zero cycles", cyc, N + 1);
    check_eq("zero in_ready cycles", rdy_cycles, K + 1);

    set_msg(26, 5'd1, -1, 5'd0);
    run_cw(0, 0, N);
    check_cw("last1", {5'd30, 5'd6, 5'd9, 5'd17});
    check_eq("last1 cycles", cyc, N + 1);

    set_msg(26, 5'd2, -1, 5'd0);
    run_cw(0, 0, N);
    check_cw("last2", {5'd25, 5'd12, 5'd18, 5'd7});

    set_msg(25, 5'd1, -1, 5'd0);
    run_cw(0, 0, N);
    check_cw("x5", {5'd21, 5'd7, 5'd4, 5'd8});

    set_msg(25, 5'd1, 26, 5'd2);
    run_cw(0, 0, N);
    check_cw("mix", {5'd12, 5'd11, 5'd22, 5'd15});
    run_cw(40, 40, N);
    check_cw("mix stall", {5'd12, 5'd11, 5'd22, 5'd15});

    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < K; i++) msg[i] = 5'($urandom_range(31));
      run_cw(30, 30, N);
      for (int i = 0; i < K; i++)
        check_eq($sformatf("rnd%0d d%0d", c, i), got_data[i], msg[i]);
      check_synd($sformatf("rnd%0d", c));
      $display("[TB] codeword rnd%0d: %0d cycles", c, cyc);
    end

    // Abort mid-parity: idx 28 is on the output when reset hits
    set_msg(26, 5'd1, -1, 5'd0);
    run_cw(0, 0, 28);
    #1;
    check_eq("pre-rst idx28", bus.out_data, 6);
    reset_n = 1'b0;
    #1;
    check_eq("midrst out_valid", bus.out_valid, 0);
    check_eq("midrst out_data", bus.out_data, 0);
    check_eq("midrst sop_eop", {bus.out_sop, bus.out_eop}, 0);
    check_eq("midrst in_ready", bus.in_ready, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run_cw(0, 0, N);
    check_cw("after rst", {5'd30, 5'd6, 5'd9, 5'd17});

`ifdef RSENC_ERR_INJECT_EN
    inj_pos = 5'd5;
    inj_mask = 5'h1F;
    run_cw(0, 0, N);
    inj_pos = 5'd0;
    inj_mask = 5'd0;
    msg[5] = 5'h1F;
    check_cw("inject", {5'd30, 5'd6, 5'd9, 5'd17});
    msg[5] = 5'd0;
    run_cw(0, 0, N);
    check_cw("inject off", {5'd30, 5'd6, 5'd9, 5'd17});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
